// File: rtl/shared_reg_arbiter.sv
// Round-robin owner arbitration for one shared WIDTH-bit register among four requesters.
// Grant is visible one cycle after the request edge; every handoff has a single idle bubble.
// Backpressure: non-owner requests wait (level Req). Define ARB_TIMEOUT_EN to reclaim after MAX_HOLD cycles.
module shared_reg_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [3:0]         Req,
    input  logic [3:0]         We,
    input  logic [4*WIDTH-1:0] D,
    output logic [3:0]         Gnt,
    output logic [WIDTH-1:0]   Q,
    output logic [1:0]         Owner,
    output logic               Busy,
    output logic               Timeout
);

    typedef enum logic [1:0] {IDLE, OWNED, RELEASE} state_t;

    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("MAX_HOLD must be at least 2");
    end

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] owner_d;
    logic [1:0] pick;
    logic [1:0] idx;
    logic       found;
    logic       do_write;
    logic       forced;
    logic [3:0] eligible;
    logic [3:0] gnt_d;

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
    logic [HW-1:0] hold_q;
    logic [3:0]    lockout_q, lockout_d;

    assign eligible = Req & ~lockout_q;
    assign forced   = (state_q == OWNED) && Req[Owner] && (hold_q == HW'(MAX_HOLD - 1));

    always_comb begin
        lockout_d = lockout_q & Req;
        if (forced) lockout_d[Owner] = 1'b1;
    end

    // Counter sits at 0 outside OWNED, so it reads 0 on the first owned cycle.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hold_q    <= '0;
            lockout_q <= '0;
            Timeout   <= 1'b0;
        end else begin
            hold_q    <= (state_q == OWNED) ? hold_q + 1'b1 : '0;
            lockout_q <= lockout_d;
            Timeout   <= forced;
        end
    end
`else
    assign eligible = Req;
    assign forced   = 1'b0;
    assign Timeout  = 1'b0;
`endif

    // First eligible requester at or after ptr, wrapping mod 4.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        idx   = ptr_q;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && eligible[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = Owner;
        do_write = 1'b0;
        case (state_q)
            IDLE, RELEASE: begin
                if (found) begin
                    state_d = OWNED;
                    owner_d = pick;
                end else begin
                    state_d = IDLE;
                end
            end
            OWNED: begin
                if (!Req[Owner]) begin
                    state_d = RELEASE;
                    ptr_d   = Owner + 2'd1;
                end else begin
                    do_write = We[Owner];
                    if (forced) begin
                        state_d = RELEASE;
                        ptr_d   = Owner + 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        gnt_d = (state_d == OWNED) ? 4'(4'b0001 << owner_d) : 4'b0000;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            Owner   <= 2'd0;
            Gnt     <= 4'b0000;
            Q       <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            Owner   <= owner_d;
            Gnt     <= gnt_d;
            if (do_write) Q <= D[Owner*WIDTH +: WIDTH];
        end
    end

    assign Busy = |Gnt;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboarded bench for shared_reg_arbiter: each step queues the expected post-edge state.
module tb_shared_reg_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  Req = '0;
    logic [3:0]  We = '0;
    logic [31:0] D = '0;
    logic [3:0]  Gnt;
    logic [7:0]  Q;
    logic [1:0]  Owner;
    logic        Busy;
    logic        Timeout;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] owner;
        logic       tmo;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] exp_q = 8'h00;
    int         n_chk = 0;
    int         n_pass = 0;

    shared_reg_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
        .Clk(Clk), .Reset(Reset), .Req(Req), .We(We), .D(D),
        .Gnt(Gnt), .Q(Q), .Owner(Owner), .Busy(Busy), .Timeout(Timeout)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_gnt"}, 32'(Gnt), 32'h0);
        chk({tag, "_q"}, 32'(Q), 32'h0);
        chk({tag, "_busy"}, 32'(Busy), 32'h0);
        chk({tag, "_owner"}, 32'(Owner), 32'h0);
        chk({tag, "_tmo"}, 32'(Timeout), 32'h0);
    endtask

    // Called at a falling edge: drive, queue expectation, then compare after the next rising edge.
    task automatic step(input string tag, input logic [3:0] rq, input logic [3:0] we,
                        input logic [31:0] d, input logic [3:0] egnt,
                        input logic [1:0] eown, input logic etmo);
        exp_t e;
        Req = rq;
        We  = we;
        D   = d;
        sb.push_back('{gnt: egnt, q: exp_q, owner: eown, tmo: etmo});
        @(posedge Clk);
        @(negedge Clk);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_gnt"}, 32'(Gnt), 32'(e.gnt));
            chk({tag, "_q"}, 32'(Q), 32'(e.q));
            chk({tag, "_owner"}, 32'(Owner), 32'(e.owner));
            chk({tag, "_busy"}, 32'(Busy), 32'(e.gnt != 4'b0000));
            chk({tag, "_tmo"}, 32'(Timeout), 32'(e.tmo));
        end
    endtask

    // Pulse Reset between edges and check it takes effect without a clock.
    task automatic pulse_reset(input string tag);
        #2;
        Reset = 1'b1;
        #1;
        Req = '0;
        We  = '0;
        check_reset_state(tag);
        exp_q = 8'h00;
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #1;
        check_reset_state("por");
        @(negedge Clk);
        Reset = 1'b0;

        // Basic grant and write
        step("b_grant", 4'b0001, 4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 1'b0);
        exp_q = 8'hA5;
        step("b_write", 4'b0001, 4'b0001, 32'h0000_00A5, 4'b0001, 2'd0, 1'b0);
        step("b_rel",   4'b0000, 4'b0001, 32'h0000_0011, 4'b0000, 2'd0, 1'b0);
        step("b_idle",  4'b0000, 4'b0000, 32'h0,         4'b0000, 2'd0, 1'b0);

        // Non-owner write is blocked (ptr=1 here, so requester 2 is found)
        step("n_grant", 4'b0100, 4'b0000, 32'h0,         4'b0100, 2'd2, 1'b0);
        step("n_block", 4'b0110, 4'b0010, 32'h0000_3C00, 4'b0100, 2'd2, 1'b0);
        exp_q = 8'h5A;
        step("n_write", 4'b0100, 4'b0100, 32'h005A_0000, 4'b0100, 2'd2, 1'b0);
        step("n_rel",   4'b0000, 4'b0000, 32'h0,         4'b0000, 2'd2, 1'b0);
        step("n_idle",  4'b0000, 4'b0000, 32'h0,         4'b0000, 2'd2, 1'b0);

        // Round-robin fairness from a clean pointer
        pulse_reset("rr_rst");
        for (int k = 0; k < 4; k++) begin
            step("rr_own",  4'b1111, 4'b0000, 32'h0, 4'(1 << k), 2'(k), 1'b0);
            step("rr_hold", 4'b1111, 4'b0000, 32'h0, 4'(1 << k), 2'(k), 1'b0);
            step("rr_bub",  4'(4'b1111 & ~(1 << k)), 4'b0000, 32'h0, 4'b0000, 2'(k), 1'b0);
        end
        step("rr_wrap", 4'b1111, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
        step("rr_rel",  4'b1110, 4'b0000, 32'h0, 4'b0000, 2'd0, 1'b0);
        step("rr_idle", 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 1'b0);

        // Simultaneous requests after requester 1 releases: ptr=2 so 3 wins
        step("s_g1",   4'b0010, 4'b0000, 32'h0, 4'b0010, 2'd1, 1'b0);
        step("s_rel",  4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd1, 1'b0);
        step("s_g3",   4'b1001, 4'b0000, 32'h0, 4'b1000, 2'd3, 1'b0);
        step("s_rel3", 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd3, 1'b0);
        step("s_idle", 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd3, 1'b0);

        // Hold timeout (ptr=0); the last owned edge also carries a write
`ifdef ARB_TIMEOUT_EN
        for (int c = 0; c < 3; c++)
            step("t_own", 4'b0011, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
        step("t_own4", 4'b0011, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
        exp_q = 8'h77;
        step("t_force",  4'b0011, 4'b0001, 32'h0000_0077, 4'b0000, 2'd0, 1'b1);
        step("t_g1",     4'b0011, 4'b0000, 32'h0, 4'b0010, 2'd1, 1'b0);
        step("t_rel1",   4'b0001, 4'b0000, 32'h0, 4'b0000, 2'd1, 1'b0);
        step("t_lock_a", 4'b0001, 4'b0000, 32'h0, 4'b0000, 2'd1, 1'b0);
        step("t_lock_b", 4'b0001, 4'b0000, 32'h0, 4'b0000, 2'd1, 1'b0);
        step("t_drop",   4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd1, 1'b0);
        step("t_regnt",  4'b0001, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
`else
        for (int c = 0; c < 4; c++)
            step("t_own", 4'b0011, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
        exp_q = 8'h77;
        step("t_nof",  4'b0011, 4'b0001, 32'h0000_0077, 4'b0001, 2'd0, 1'b0);
        for (int c = 0; c < 3; c++)
            step("t_keep", 4'b0011, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
`endif
        step("t_rel",  4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 1'b0);
        step("t_idle", 4'b0000, 4'b0000, 32'h0, 4'b0000, 2'd0, 1'b0);

        // Async reset mid-ownership (ptr=1, so requester 2 is found)
        step("a_grant", 4'b0100, 4'b0100, 32'h00FF_0000, 4'b0100, 2'd2, 1'b0);
        exp_q = 8'hFF;
        step("a_write", 4'b0100, 4'b0100, 32'h00FF_0000, 4'b0100, 2'd2, 1'b0);
        Req = 4'b0100;
        We  = 4'b0100;
        pulse_reset("a_rst");
        step("a_ptr0", 4'b1001, 4'b0000, 32'h0, 4'b0001, 2'd0, 1'b0);
        step("a_rel",  4'b1000, 4'b0000, 32'h0, 4'b0000, 2'd0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
